// File: rtl/pipelined_mips_core.sv
// pipelined_mips_core: 5-stage MIPS32 integer subset CPU with internal imem/dmem.
// Define FORWARDING_EN to enable EX bypassing from EX/MEM and MEM/WB; otherwise ID interlocks.
module mips_imem #(
  parameter int WORDS = 256,
  localparam int AW = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] mem_data [0:WORDS-1];
  assign rdata = mem_data[addr];
endmodule

module mips_dmem #(
  parameter int WORDS = 256,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_data [0:WORDS-1];
  assign rdata = mem_data[addr];
  always_ff @(posedge clk)
    if (we) mem_data[addr] <= wdata;
endmodule

module pipelined_mips_core #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [2:0] A_ADD = 3'd0, A_OR = 3'd1, A_XOR = 3'd2, A_SLT = 3'd3, A_SLTU = 3'd4;
  logic [31:0] PC, imem_rdata, dmem_rdata;
  logic [31:0] ifid_ir, ifid_pc4;
  logic        ex_we, ex_lw, ex_sw, ex_beq, ex_bne, ex_isimm;
  logic [4:0]  ex_dst;
  logic [2:0]  ex_alu;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic        mem_we, mem_lw, mem_sw;
  logic [4:0]  mem_dst;
  logic [31:0] mem_res, mem_sd;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_val;
  logic [31:0] rf [0:31];
  mips_imem #(.WORDS(IMEM_WORDS)) imem (.addr(PC[IAW+1:2]), .rdata(imem_rdata));
  mips_dmem #(.WORDS(DMEM_WORDS)) dmem (
    .clk(clk), .we(mem_sw), .addr(mem_res[DAW+1:2]), .wdata(mem_sd), .rdata(dmem_rdata)
  );
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, d_dst;
  logic [15:0] imm;
  logic        r_ok, i_add, is_ori, is_xori, is_lw, is_sw, is_beq, is_bne;
  logic        d_we, d_use_rs, d_use_rt;
  logic [2:0]  d_alu;
  logic [31:0] d_imm, rs_val, rt_val;
  assign {op, rs, rt, rd} = ifid_ir[31:11];
  assign fn  = ifid_ir[5:0];
  assign imm = ifid_ir[15:0];
  assign r_ok    = op == 6'h00 && (fn == 6'h20 || fn == 6'h21 || fn == 6'h26 || fn == 6'h2a || fn == 6'h2b);
  assign i_add   = op == 6'h08 || op == 6'h09;
  assign is_ori  = op == 6'h0d;
  assign is_xori = op == 6'h0e;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign d_alu = r_ok ? (fn == 6'h26 ? A_XOR : fn == 6'h2a ? A_SLT : fn == 6'h2b ? A_SLTU : A_ADD)
               : is_ori ? A_OR : is_xori ? A_XOR : A_ADD;
  assign d_dst    = r_ok ? rd : rt;
  assign d_we     = (r_ok || i_add || is_ori || is_xori || is_lw) && d_dst != 5'd0;
  assign d_imm    = (is_ori || is_xori) ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign d_use_rt = r_ok || is_sw || is_beq || is_bne;
  assign d_use_rs = d_use_rt || i_add || is_ori || is_xori || is_lw;
  // WB write is visible to the ID read in the same cycle
  assign rs_val = (wb_we && wb_dst == rs) ? wb_val : rf[rs];
  assign rt_val = (wb_we && wb_dst == rt) ? wb_val : rf[rt];
  logic dep_ex, load_use, stall, taken, bub;
  logic [31:0] fa, fb, alu_b, alu_res, target;
  assign dep_ex   = ex_we && ((d_use_rs && ex_dst == rs) || (d_use_rt && ex_dst == rt));
  assign load_use = ex_lw && dep_ex;
`ifdef FORWARDING_EN
  logic [4:0] ex_rs, ex_rt;
  assign stall = load_use;
  assign fa = (mem_we && mem_dst == ex_rs) ? mem_res : (wb_we && wb_dst == ex_rs) ? wb_val : ex_a;
  assign fb = (mem_we && mem_dst == ex_rt) ? mem_res : (wb_we && wb_dst == ex_rt) ? wb_val : ex_b;
  always_ff @(posedge clk or posedge reset)
    if (reset) {ex_rs, ex_rt} <= '0;
    else {ex_rs, ex_rt} <= {rs, rt};
`else
  logic dep_mem;
  assign dep_mem = mem_we && ((d_use_rs && mem_dst == rs) || (d_use_rt && mem_dst == rt));
  assign stall = dep_ex || dep_mem;
  assign fa = ex_a;
  assign fb = ex_b;
`endif
  assign alu_b   = ex_isimm ? ex_imm : fb;
  assign alu_res = ex_alu == A_OR   ? fa | alu_b
                 : ex_alu == A_XOR  ? fa ^ alu_b
                 : ex_alu == A_SLT  ? {31'h0, $signed(fa) < $signed(alu_b)}
                 : ex_alu == A_SLTU ? {31'h0, fa < alu_b}
                 : fa + alu_b;
  assign taken  = (ex_beq && fa == fb) || (ex_bne && fa != fb);
  assign target = ex_pc4 + {ex_imm[29:0], 2'b00};
  // a taken branch overrides a simultaneous stall
  assign bub = taken || stall;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      PC <= RESET_PC;
      {ifid_ir, ifid_pc4} <= '0;
      {ex_we, ex_lw, ex_sw, ex_beq, ex_bne, ex_isimm, ex_dst, ex_alu} <= '0;
      {ex_a, ex_b, ex_imm, ex_pc4} <= '0;
      {mem_we, mem_lw, mem_sw, mem_dst, mem_res, mem_sd} <= '0;
      {wb_we, wb_dst, wb_val} <= '0;
    end else begin
      PC       <= taken ? target : stall ? PC : PC + 32'd4;
      ifid_ir  <= taken ? 32'h0 : stall ? ifid_ir : imem_rdata;
      ifid_pc4 <= stall ? ifid_pc4 : PC + 32'd4;
      ex_we    <= d_we && !bub;
      ex_lw    <= is_lw && !bub;
      ex_sw    <= is_sw && !bub;
      ex_beq   <= is_beq && !bub;
      ex_bne   <= is_bne && !bub;
      ex_isimm <= !r_ok;
      ex_dst   <= d_dst;
      ex_alu   <= d_alu;
      ex_a     <= rs_val;
      ex_b     <= rt_val;
      ex_imm   <= d_imm;
      ex_pc4   <= ifid_pc4;
      mem_we   <= ex_we;
      mem_lw   <= ex_lw;
      mem_sw   <= ex_sw;
      mem_dst  <= ex_dst;
      mem_res  <= alu_res;
      mem_sd   <= fb;
      wb_we    <= mem_we;
      wb_dst   <= mem_dst;
      wb_val   <= mem_lw ? dmem_rdata : mem_res;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    else if (wb_we) rf[wb_dst] <= wb_val;
endmodule

// File: tb/tb_pipelined_mips_core.sv
// tb_pipelined_mips_core: loads small programs into imem, runs to the PC==0x80 end marker,
// and compares GPR/dmem state against scoreboard expectations built by the bench.
module tb_pipelined_mips_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pipelined_mips_core dut (.clk(clk), .reset(reset));
  typedef struct { string name; bit mem; int idx; logic [31:0] val; } exp_t;
  exp_t sb[$];
  logic [31:0] prog[$];
  int checks = 0, failures = 0;
  int lu_cnt = 0;
  always @(posedge clk) lu_cnt <= lu_cnt + (dut.load_use === 1'b1 ? 1 : 0);
  function automatic logic [31:0] r_(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction
  function automatic logic [31:0] i_(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic void expect_reg(input string n, input int r, input logic [31:0] v);
    sb.push_back('{n, 1'b0, r, v});
  endfunction
  function automatic void expect_mem(input string n, input int w, input logic [31:0] v);
    sb.push_back('{n, 1'b1, w, v});
  endfunction
  task automatic run(input int budget, output bit done, output int lu);
    int n, lu0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem.mem_data[i] = (i < prog.size()) ? prog[i] : 32'h0;
    dut.imem.mem_data[30] = i_(4, 0, 0, -1);
    repeat (3) @(negedge clk);
    lu0 = lu_cnt;
    reset = 1'b0;
    n = 0;
    while (dut.PC !== 32'h80 && n < budget) begin
      @(negedge clk);
      n++;
    end
    done = dut.PC === 32'h80;
    repeat (6) @(negedge clk);
    lu = lu_cnt - lu0;
  endtask
  task automatic test_reset();
    bit done;
    int lu, nz;
    exp_t e;
    prog = '{i_(13, 1, 0, 7), i_(13, 2, 0, 9)};
    expect_reg("pre_r1", 1, 32'd7);
    expect_reg("pre_r2", 2, 32'd9);
    run(200, done, lu);
    checks++;
    if (!done) begin failures++; $display("FAIL reset_run timeout PC=%h required 00000080", dut.PC); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.rf[e.idx] !== e.val) begin failures++; $display("FAIL %s got %h required %h", e.name, dut.rf[e.idx], e.val); end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf[i] !== 32'h0) nz++;
    checks++;
    if (dut.PC !== 32'h0) begin failures++; $display("FAIL async_pc got %h required 00000000", dut.PC); end
    checks++;
    if (nz !== 0) begin failures++; $display("FAIL async_gprs nonzero=%0d required 0", nz); end
    dut.dmem.mem_data[5] = 32'hA5A5A5A5;
    dut.imem.mem_data[0] = i_(43, 0, 0, 20);
    repeat (3) @(negedge clk);
    checks++;
    if (dut.PC !== 32'h0) begin failures++; $display("FAIL hold_pc got %h required 00000000", dut.PC); end
    checks++;
    if (dut.dmem.mem_data[5] !== 32'hA5A5A5A5) begin failures++; $display("FAIL hold_dmem got %h required a5a5a5a5", dut.dmem.mem_data[5]); end
  endtask
  task automatic test_alu();
    bit done;
    int lu;
    exp_t e;
    prog = '{i_(13, 3, 0, 16'hDEAD), i_(14, 3, 3, 16'hBEEF), i_(9, 4, 0, -1), i_(13, 5, 0, 1),
             r_(42, 6, 4, 5), r_(43, 7, 4, 5), r_(32, 8, 4, 5), i_(8, 9, 0, -2), r_(38, 10, 4, 5),
             r_(33, 11, 5, 5), i_(13, 0, 0, 5), r_(42, 12, 5, 4), r_(43, 13, 5, 4),
             i_(13, 14, 0, 16'h8000), i_(9, 15, 0, 16'h8000), r_(34, 16, 4, 5), i_(13, 17, 0, 0)};
    expect_reg("ori_xori", 3, 32'h00006042);
    expect_reg("addiu_neg", 4, 32'hFFFFFFFF);
    expect_reg("slt_neg", 6, 32'd1);
    expect_reg("sltu_big", 7, 32'd0);
    expect_reg("add_wrap", 8, 32'd0);
    expect_reg("addi_neg", 9, 32'hFFFFFFFE);
    expect_reg("xor_r", 10, 32'hFFFFFFFE);
    expect_reg("addu", 11, 32'd2);
    expect_reg("zero_reg", 0, 32'd0);
    expect_reg("slt_pos", 12, 32'd0);
    expect_reg("sltu_small", 13, 32'd1);
    expect_reg("ori_zext", 14, 32'h00008000);
    expect_reg("addiu_sext", 15, 32'hFFFF8000);
    expect_reg("unknown_nop", 16, 32'd0);
    run(300, done, lu);
    checks++;
    if (!done) begin failures++; $display("FAIL alu_run timeout PC=%h required 00000080", dut.PC); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.rf[e.idx] !== e.val) begin failures++; $display("FAIL %s got %h required %h", e.name, dut.rf[e.idx], e.val); end
    end
  endtask
  task automatic test_forwarding();
    bit done;
    int lu;
    exp_t e;
    logic [31:0] act;
    prog = '{i_(13, 3, 0, 5), r_(32, 2, 3, 3), r_(38, 2, 2, 3), i_(13, 20, 0, 1), r_(33, 21, 20, 20),
             r_(33, 22, 21, 20), i_(43, 22, 0, 16'h40), i_(5, 22, 21, 1), i_(13, 23, 0, 16'hBAD),
             i_(13, 24, 0, 16'h77)};
    expect_reg("fwd_xor", 2, 32'h0000000F);
    expect_reg("fwd_chain", 22, 32'd3);
    expect_mem("fwd_sw", 16, 32'd3);
    expect_reg("fwd_bne_skip", 23, 32'd0);
    expect_reg("fwd_bne_tgt", 24, 32'h77);
    run(300, done, lu);
    checks++;
    if (!done) begin failures++; $display("FAIL fwd_run timeout PC=%h required 00000080", dut.PC); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem.mem_data[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.val) begin failures++; $display("FAIL %s got %h required %h", e.name, act, e.val); end
    end
  endtask
  task automatic test_load_use();
    bit done;
    int lu;
    exp_t e;
    logic [31:0] act;
    dut.dmem.mem_data[32] = 32'h0;
    prog = '{i_(13, 11, 0, 16'h1234), i_(43, 11, 0, 16'h80), i_(35, 12, 0, 16'h80), r_(32, 13, 12, 12)};
    expect_mem("lu_sw", 32, 32'h1234);
    expect_reg("lu_lw", 12, 32'h1234);
    expect_reg("lu_add", 13, 32'h2468);
    run(300, done, lu);
    checks++;
    if (!done) begin failures++; $display("FAIL lu_run timeout PC=%h required 00000080", dut.PC); end
    checks++;
    if (lu !== 1) begin failures++; $display("FAIL lu_stalls got %0d required 1", lu); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem.mem_data[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.val) begin failures++; $display("FAIL %s got %h required %h", e.name, act, e.val); end
    end
  endtask
  task automatic test_branch();
    bit done;
    int lu;
    exp_t e;
    prog = '{i_(13, 1, 0, 1), i_(5, 1, 0, 2), i_(13, 2, 0, 16'hBAD), i_(13, 3, 0, 16'hBAD),
             i_(13, 4, 0, 16'h600D), i_(4, 0, 1, 1), i_(13, 5, 0, 7), i_(4, 5, 5, 2),
             i_(13, 6, 0, 16'hBAD), i_(13, 7, 0, 16'hBAD), i_(13, 8, 0, 8)};
    expect_reg("bne_skip1", 2, 32'd0);
    expect_reg("bne_skip2", 3, 32'd0);
    expect_reg("bne_target", 4, 32'h600D);
    expect_reg("beq_not_taken", 5, 32'd7);
    expect_reg("beq_skip1", 6, 32'd0);
    expect_reg("beq_skip2", 7, 32'd0);
    expect_reg("beq_target", 8, 32'd8);
    run(300, done, lu);
    checks++;
    if (!done) begin failures++; $display("FAIL br_run timeout PC=%h required 00000080", dut.PC); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.rf[e.idx] !== e.val) begin failures++; $display("FAIL %s got %h required %h", e.name, dut.rf[e.idx], e.val); end
    end
  endtask
  task automatic test_sort();
    bit done;
    int lu;
    exp_t e;
    logic [31:0] x, t, act;
    logic [31:0] m[96];
    x = 32'h1234_5678;
    for (int i = 0; i < 96; i++) begin
      x = x * 32'd1664525 + 32'd1013904223;
      m[i] = x;
      dut.dmem.mem_data[32 + i] = x;
    end
    for (int i = 1; i < 96; i++)
      for (int j = i; j > 0 && m[j-1] < m[j]; j--) begin
        t = m[j];
        m[j] = m[j-1];
        m[j-1] = t;
      end
    for (int i = 0; i < 96; i++) expect_mem($sformatf("sort_w%0d", 32 + i), 32 + i, m[i]);
    prog = '{i_(13, 1, 0, 16'h84), i_(13, 2, 0, 16'h200), i_(13, 7, 0, 16'h7C), i_(35, 3, 1, 0),
             i_(9, 4, 1, -4), i_(35, 5, 4, 0), r_(43, 6, 5, 3), i_(4, 0, 6, 3), i_(43, 5, 4, 4),
             i_(9, 4, 4, -4), i_(5, 7, 4, -6), i_(43, 3, 4, 4), i_(9, 1, 1, 4), i_(5, 2, 1, -11)};
    run(90000, done, lu);
    checks++;
    if (!done) begin failures++; $display("FAIL sort_run timeout PC=%h required 00000080", dut.PC); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = dut.dmem.mem_data[e.idx];
      checks++;
      if (act !== e.val) begin failures++; $display("FAIL %s got %h required %h", e.name, act, e.val); end
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_forwarding();
    test_load_use();
    test_branch();
    test_sort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
